// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: FSM states, request kinds and the request register layout.
package alu_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_A, EXEC, WB} seq_state_t;

  typedef enum logic [1:0] {
    ALU_OP    = 2'b00,
    PC_INC    = 2'b01,
    ADDR_CALC = 2'b10,
    RSVD      = 2'b11
  } req_kind_t;

  typedef struct packed {
    req_kind_t   kind;
    logic [3:0]  op_code;
    logic [4:0]  shift;
    logic        carry_in;
  } seq_req_t;

  // PC_INC has no A operand, reserved requests have nothing to execute.
  function automatic seq_state_t first_state(input req_kind_t kind);
    case (kind)
      ALU_OP, ADDR_CALC: first_state = LOAD_A;
      PC_INC:            first_state = EXEC;
      default:           first_state = WB;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of sequencer state + captured request into bus selection,
// alu_driver strobes and writeback controls.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 4
) (
  input  seq_state_t           state,
  input  seq_req_t             req,
  input  logic [RF_ADDR_W-1:0] src_a,
  input  logic [RF_ADDR_W-1:0] src_b,
  input  logic [RF_ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0]    rf_rd_data,
  input  logic [DATA_W-1:0]    pc_value,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_error,
  output logic [RF_ADDR_W-1:0] rf_rd_addr,
  output logic                 rf_wr_en,
  output logic [RF_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic                 pc_wr_en,
  output logic [DATA_W-1:0]    pc_wr_data,
  output logic [DATA_W-1:0]    bus_out,
  output logic                 alu_in_load,
  output logic                 alu_out_load,
  output logic                 alu_pc_update,
  output logic                 alu_forced_add,
  output logic [3:0]           alu_op_code,
  output logic [4:0]           alu_shift,
  output logic                 alu_carry_in,
  output logic                 done,
  output logic                 done_error
);

  always_comb begin
    rf_rd_addr     = '0;
    rf_wr_en       = 1'b0;
    rf_wr_addr     = '0;
    rf_wr_data     = '0;
    pc_wr_en       = 1'b0;
    pc_wr_data     = '0;
    bus_out        = '0;
    alu_in_load    = 1'b0;
    alu_out_load   = 1'b0;
    alu_pc_update  = 1'b0;
    alu_forced_add = 1'b0;
    alu_op_code    = '0;
    alu_shift      = '0;
    alu_carry_in   = 1'b0;
    done           = 1'b0;
    done_error     = 1'b0;

    case (state)
      LOAD_A: begin
        rf_rd_addr  = src_a;
        bus_out     = rf_rd_data;
        alu_in_load = 1'b1;
      end
      EXEC: begin
        alu_out_load = 1'b1;
        alu_op_code  = req.op_code;
        alu_shift    = req.shift;
        alu_carry_in = req.carry_in;
        if (req.kind == PC_INC) begin
          bus_out        = pc_value;
          alu_pc_update  = 1'b1;
          alu_forced_add = 1'b1;
        end else begin
          rf_rd_addr     = src_b;
          bus_out        = rf_rd_data;
          alu_forced_add = (req.kind == ADDR_CALC);
        end
      end
      WB: begin
        done = 1'b1;
        // An ALU error retires the request without committing anything.
        case (req.kind)
          ALU_OP, ADDR_CALC: begin
            rf_wr_en   = !alu_error;
            rf_wr_addr = dst;
            rf_wr_data = alu_result;
            done_error = alu_error;
          end
          PC_INC: begin
            pc_wr_en   = !alu_error;
            pc_wr_data = alu_result;
            done_error = alu_error;
          end
          default: done_error = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Steps alu_driver through register-file read, execute and writeback for one request at a time.
// Define ALU_SEQ_OVERLAP_EN to also accept a new request during WB.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_kind,
  input  logic [3:0]           req_op_code,
  input  logic [4:0]           req_shift,
  input  logic                 req_carry_in,
  input  logic [RF_ADDR_W-1:0] req_src_a,
  input  logic [RF_ADDR_W-1:0] req_src_b,
  input  logic [RF_ADDR_W-1:0] req_dst,
  output logic [RF_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]    rf_rd_data,
  output logic                 rf_wr_en,
  output logic [RF_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]    rf_wr_data,
  input  logic [DATA_W-1:0]    pc_value,
  output logic                 pc_wr_en,
  output logic [DATA_W-1:0]    pc_wr_data,
  output logic [DATA_W-1:0]    bus_out,
  output logic                 alu_in_load,
  output logic                 alu_out_load,
  output logic                 alu_pc_update,
  output logic                 alu_forced_add,
  output logic [3:0]           alu_op_code,
  output logic [4:0]           alu_shift,
  output logic                 alu_carry_in,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_error,
  output logic                 done,
  output logic                 done_error
);

  seq_state_t           state, next_state;
  seq_req_t             req_q;
  logic [RF_ADDR_W-1:0] src_a_q, src_b_q, dst_q;
  logic                 ready_en;
  logic                 accept;

  // Keeps req_ready low while in reset and until the first edge after release.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

`ifdef ALU_SEQ_OVERLAP_EN
  assign req_ready = ready_en & ((state == IDLE) | (state == WB));
`else
  assign req_ready = ready_en & (state == IDLE);
`endif

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = first_state(req_kind_t'(req_kind));
      LOAD_A:  next_state = EXEC;
      EXEC:    next_state = WB;
      WB:      next_state = accept ? first_state(req_kind_t'(req_kind)) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      req_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
    end else if (accept) begin
      req_q   <= '{kind: req_kind_t'(req_kind), op_code: req_op_code,
                   shift: req_shift, carry_in: req_carry_in};
      src_a_q <= req_src_a;
      src_b_q <= req_src_b;
      dst_q   <= req_dst;
    end
  end

  alu_seq_decode #(.DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W)) u_decode (
    .state          (state),
    .req            (req_q),
    .src_a          (src_a_q),
    .src_b          (src_b_q),
    .dst            (dst_q),
    .rf_rd_data     (rf_rd_data),
    .pc_value       (pc_value),
    .alu_result     (alu_result),
    .alu_error      (alu_error),
    .rf_rd_addr     (rf_rd_addr),
    .rf_wr_en       (rf_wr_en),
    .rf_wr_addr     (rf_wr_addr),
    .rf_wr_data     (rf_wr_data),
    .pc_wr_en       (pc_wr_en),
    .pc_wr_data     (pc_wr_data),
    .bus_out        (bus_out),
    .alu_in_load    (alu_in_load),
    .alu_out_load   (alu_out_load),
    .alu_pc_update  (alu_pc_update),
    .alu_forced_add (alu_forced_add),
    .alu_op_code    (alu_op_code),
    .alu_shift      (alu_shift),
    .alu_carry_in   (alu_carry_in),
    .done           (done),
    .done_error     (done_error)
  );

endmodule
